// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Purpose  : Write-back stage and integer register file of the 64-bit
//            pipeline. Accepts the memory-access stage result, writes it into
//            a 32 x XLEN register array and tracks outstanding producers in a
//            pending-write scoreboard. It also counts accepted write-backs.
//
// Ports    : CLK        - pipeline clock, all state changes on rising edge
//            RST_N      - asynchronous active-low reset
//            wb_en      - write-back valid from the memory-access stage
//            wb_rd      - write-back destination register
//            wb_data    - write-back value
//            issue_en   - decode issued an instruction that writes a register
//            issue_rd   - destination of that issued instruction
//            flush      - pipeline flush, clears the scoreboard
//            rs1_addr   - read port 1 address
//            rs2_addr   - read port 2 address
//            rs1_data   - read port 1 data (combinational)
//            rs2_data   - read port 2 data (combinational)
//            rs1_busy   - rs1 has an outstanding producer
//            rs2_busy   - rs2 has an outstanding producer
//            retire_cnt - number of accepted write-backs (wraps silently)
//
// Options  : WB_BYPASS_EN - when defined, a same-cycle write-back is forwarded
//            to the read ports and masks the matching busy output.
//
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile #(
  parameter int XLEN  = 64,
  parameter int NREG  = 32,
  parameter int CNT_W = 64
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    wb_en,
  input  logic [$clog2(NREG)-1:0] wb_rd,
  input  logic [XLEN-1:0]         wb_data,
  input  logic                    issue_en,
  input  logic [$clog2(NREG)-1:0] issue_rd,
  input  logic                    flush,
  input  logic [$clog2(NREG)-1:0] rs1_addr,
  input  logic [$clog2(NREG)-1:0] rs2_addr,
  output logic [XLEN-1:0]         rs1_data,
  output logic [XLEN-1:0]         rs2_data,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic [CNT_W-1:0]        retire_cnt
);

  localparam int AW = $clog2(NREG);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [XLEN-1:0]  regs [NREG];
  logic [NREG-1:0]  busy;
  logic [CNT_W-1:0] cnt;

  // One-hot decodes of the events that touch the array and the scoreboard.
  logic [NREG-1:0] wr_sel;   // register written this edge (never x0)
  logic [NREG-1:0] clr_sel;  // scoreboard bit cleared by the write-back
  logic [NREG-1:0] set_sel;  // scoreboard bit set by the issue (never x0)
  logic [NREG-1:0] busy_nxt;

  always_comb begin
    wr_sel  = '0;
    clr_sel = '0;
    set_sel = '0;
    if (wb_en && (wb_rd != '0)) begin
      wr_sel[wb_rd] = 1'b1;
    end
    if (wb_en) begin
      clr_sel[wb_rd] = 1'b1;
    end
    if (issue_en && (issue_rd != '0)) begin
      set_sel[issue_rd] = 1'b1;
    end
  end

  // Set is applied after clear so that a new producer issued on the same edge
  // as the retiring one keeps the register busy. A flush discards everything,
  // including a same-edge issue. Bit 0 is pinned low so x0 never looks busy.
  always_comb begin
    busy_nxt = '0;
    if (!flush) begin
      busy_nxt = (busy & ~clr_sel) | set_sel;
    end
    busy_nxt[0] = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Register array. Entry 0 is reset but never written; reads of x0 are also
  // forced to zero below, so the storage behind it is effectively dead.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (wr_sel[i]) begin
          regs[i] <= wb_data;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard and retire counter. The flush does not touch the counter: a
  // write-back that lands during a flush is still an accepted write-back.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (wb_en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign retire_cnt = cnt;

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
`ifdef WB_BYPASS_EN
  // A write-back to the addressed register this cycle is forwarded so that
  // the consumer need not wait for the array update. The same condition
  // means the producer is retiring now, so the busy output is masked. A
  // same-cycle issue is deliberately not considered: busy reflects only the
  // registered vector.
  logic hit1;
  logic hit2;

  assign hit1 = wb_en && (wb_rd != '0) && (wb_rd == rs1_addr);
  assign hit2 = wb_en && (wb_rd != '0) && (wb_rd == rs2_addr);

  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
    if (hit1) begin
      rs1_data = wb_data;
    end
    if (hit2) begin
      rs2_data = wb_data;
    end
  end

  assign rs1_busy = busy[rs1_addr] & ~hit1;
  assign rs2_busy = busy[rs2_addr] & ~hit2;
`else
  // Registered array only: during a write cycle the old value is returned.
  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
  end

  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];
`endif

  // The index width is tied to NREG; keep the two consistent.
  logic unused_aw;
  assign unused_aw = (AW == $clog2(NREG));

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Purpose  : Self-checking bench for wb_regfile. A vector table covers the
//            basic write/read/scoreboard behaviour, hand sequences cover the
//            bypass, flush and asynchronous-reset corners, and a random phase
//            is compared against an array-based reference model. A second
//            instance with a 4-bit counter exercises counter wrap-around.
// Options  : WB_BYPASS_EN - expectations follow the DUT build option.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        flush;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [63:0] retire_cnt;

  logic [63:0] w_rs1_data;
  logic [63:0] w_rs2_data;
  logic        w_rs1_busy;
  logic        w_rs2_busy;
  logic [3:0]  w_retire_cnt;

  always #5 CLK = ~CLK;

  wb_regfile #(.XLEN(64), .NREG(32), .CNT_W(64)) u_dut (
    .CLK(CLK), .RST_N(RST_N),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .retire_cnt(retire_cnt)
  );

  wb_regfile #(.XLEN(64), .NREG(32), .CNT_W(4)) u_dut_w (
    .CLK(CLK), .RST_N(RST_N),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(w_rs1_data), .rs2_data(w_rs2_data),
    .rs1_busy(w_rs1_busy), .rs2_busy(w_rs2_busy),
    .retire_cnt(w_retire_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: architectural state only.
  logic [63:0] m_regs [32];
  logic        m_busy [32];
  logic [63:0] m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_cnt = '0;
  endtask

  // Effect of one rising edge given the inputs currently applied.
  task automatic model_edge();
    if (wb_en) m_cnt = m_cnt + 64'd1;
    if (wb_en && wb_rd != 0) m_regs[wb_rd] = wb_data;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (wb_en) m_busy[wb_rd] = 1'b0;
      if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    end
  endtask

  function automatic logic [63:0] exp_data(input logic [4:0] a);
    if (a == 0) return 64'd0;
`ifdef WB_BYPASS_EN
    if (wb_en && wb_rd == a) return wb_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    logic b;
    b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef WB_BYPASS_EN
    if (wb_en && wb_rd == a && a != 0) b = 1'b0;
`endif
    return b;
  endfunction

  task automatic set_in(input logic we, input logic [4:0] wrd, input logic [63:0] wd,
                        input logic ie, input logic [4:0] ird, input logic fl,
                        input logic [4:0] a1, input logic [4:0] a2);
    wb_en = we; wb_rd = wrd; wb_data = wd;
    issue_en = ie; issue_rd = ird; flush = fl;
    rs1_addr = a1; rs2_addr = a2;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".rs1_data"}, rs1_data, exp_data(rs1_addr));
    check({tag, ".rs2_data"}, rs2_data, exp_data(rs2_addr));
    check({tag, ".rs1_busy"}, {63'd0, rs1_busy}, {63'd0, exp_busy(rs1_addr)});
    check({tag, ".rs2_busy"}, {63'd0, rs2_busy}, {63'd0, exp_busy(rs2_addr)});
    check({tag, ".retire_cnt"}, retire_cnt, m_cnt);
    check({tag, ".retire_cnt4"}, {60'd0, w_retire_cnt}, {60'd0, m_cnt[3:0]});
  endtask

  // Inputs change at the falling edge; DUT and model advance on the rising one.
  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  typedef struct packed {
    logic        we;
    logic [4:0]  wrd;
    logic [63:0] wd;
    logic        ie;
    logic [4:0]  ird;
    logic        fl;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [63:0] e1;
    logic        eb1;
    logic [63:0] e2;
    logic        eb2;
    logic [63:0] ecnt;
  } vec_t;

  vec_t tbl [8];

  initial begin
    // Expected outputs are those seen before the vector's own edge.
    tbl[0] = '{1'b1, 5'd5, 64'h1122334455667788, 1'b0, 5'd0, 1'b0, 5'd1, 5'd2,
               64'd0, 1'b0, 64'd0, 1'b0, 64'd0};
    tbl[1] = '{1'b1, 5'd0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 5'd0, 1'b0, 5'd5, 5'd0,
               64'h1122334455667788, 1'b0, 64'd0, 1'b0, 64'd1};
    tbl[2] = '{1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd0,
               64'd0, 1'b0, 64'd0, 1'b0, 64'd2};
    tbl[3] = '{1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd5,
               64'd0, 1'b1, 64'h1122334455667788, 1'b0, 64'd2};
    tbl[4] = '{1'b1, 5'd9, 64'h33, 1'b1, 5'd9, 1'b0, 5'd3, 5'd4,
               64'd0, 1'b0, 64'd0, 1'b0, 64'd2};
    tbl[5] = '{1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0,
               64'h33, 1'b1, 64'd0, 1'b0, 64'd3};
    tbl[6] = '{1'b1, 5'd9, 64'h44, 1'b0, 5'd0, 1'b0, 5'd5, 5'd1,
               64'h1122334455667788, 1'b0, 64'd0, 1'b0, 64'd3};
    tbl[7] = '{1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd9,
               64'h44, 1'b0, 64'h44, 1'b0, 64'd4};

    // ---------------- reset state, including an edge held in reset ---------
    RST_N = 1'b0;
    model_reset();
    set_in(1'b1, 5'd5, 64'hDEAD, 1'b1, 5'd6, 1'b0, 5'd6, 5'd5);
    #2;
    check("rst.rs1_data", rs1_data, 64'd0);
    check("rst.rs1_busy", {63'd0, rs1_busy}, 64'd0);
    check("rst.retire_cnt", retire_cnt, 64'd0);
    @(negedge CLK);
    @(negedge CLK);
    set_in(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd6);
    #1;
    check("rst_edge.rs1_data", rs1_data, 64'd0);
    check("rst_edge.rs2_busy", {63'd0, rs2_busy}, 64'd0);
    check("rst_edge.retire_cnt", retire_cnt, 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // ---------------- vector table ----------------------------------------
    for (int i = 0; i < 8; i++) begin
      set_in(tbl[i].we, tbl[i].wrd, tbl[i].wd, tbl[i].ie, tbl[i].ird, tbl[i].fl,
             tbl[i].a1, tbl[i].a2);
      #1;
      check($sformatf("vec%0d.rs1_data", i), rs1_data, tbl[i].e1);
      check($sformatf("vec%0d.rs1_busy", i), {63'd0, rs1_busy}, {63'd0, tbl[i].eb1});
      check($sformatf("vec%0d.rs2_data", i), rs2_data, tbl[i].e2);
      check($sformatf("vec%0d.rs2_busy", i), {63'd0, rs2_busy}, {63'd0, tbl[i].eb2});
      check($sformatf("vec%0d.retire_cnt", i), retire_cnt, tbl[i].ecnt);
      tick();
    end

    // ---------------- same-cycle write visibility -------------------------
    set_in(1'b1, 5'd7, 64'hA, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    tick();
    set_in(1'b1, 5'd7, 64'hB, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
    #1;
`ifdef WB_BYPASS_EN
    check("bypass.rs2_data", rs2_data, 64'hB);
`else
    check("bypass.rs2_data", rs2_data, 64'hA);
`endif
    tick();
    set_in(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
    #1;
    check("bypass_next.rs2_data", rs2_data, 64'hB);

    // ---------------- flush -----------------------------------------------
    set_in(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 1'b0, 5'd0, 5'd0);
    tick();
    set_in(1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 1'b0, 5'd0, 5'd0);
    tick();
    set_in(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 1'b0, 5'd0, 5'd0);
    tick();
    set_in(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd4);
    #1;
    check("preflush.rs1_busy", {63'd0, rs1_busy}, 64'd1);
    check("preflush.rs2_busy", {63'd0, rs2_busy}, 64'd1);
    set_in(1'b1, 5'd4, 64'h55, 1'b1, 5'd3, 1'b1, 5'd31, 5'd3);
    #1;
    check("flush_cyc.rs1_busy", {63'd0, rs1_busy}, 64'd1);
    tick();
    set_in(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd4);
    #1;
    check("postflush.rs1_busy", {63'd0, rs1_busy}, 64'd0);
    check("postflush.rs2_busy", {63'd0, rs2_busy}, 64'd0);
    check("postflush.rs2_data", rs2_data, 64'h55);
    rs1_addr = 5'd31;
    #1;
    check("postflush.r31_busy", {63'd0, rs1_busy}, 64'd0);

    // ---------------- asynchronous reset mid-stream -----------------------
    @(negedge CLK);
    RST_N = 1'b0;
    #2;
    RST_N = 1'b1;
    model_reset();
    @(negedge CLK);
    set_in(1'b1, 5'd12, 64'h99, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    tick();
    set_in(1'b1, 5'd0, 64'h1, 1'b1, 5'd12, 1'b0, 5'd0, 5'd0);
    tick();
    set_in(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd12, 5'd12);
    #1;
    check("prearst.rs1_data", rs1_data, 64'h99);
    check("prearst.rs1_busy", {63'd0, rs1_busy}, 64'd1);
    check("prearst.retire_cnt", retire_cnt, 64'd2);
    #1;
    RST_N = 1'b0;
    #1;
    check("arst.rs1_data", rs1_data, 64'd0);
    check("arst.rs1_busy", {63'd0, rs1_busy}, 64'd0);
    check("arst.retire_cnt", retire_cnt, 64'd0);
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;

    // ---------------- randomized phase against the model ------------------
    for (int n = 0; n < 400; n++) begin
      logic [4:0] r_wrd;
      logic [4:0] r_ird;
      logic [4:0] r_a1;
      logic [4:0] r_a2;
      // Narrow address range most of the time to provoke collisions.
      if ($urandom_range(0, 3) != 0) begin
        r_wrd = 5'($urandom_range(0, 7));
        r_ird = 5'($urandom_range(0, 7));
        r_a1  = 5'($urandom_range(0, 7));
        r_a2  = 5'($urandom_range(0, 7));
      end else begin
        r_wrd = 5'($urandom_range(0, 31));
        r_ird = 5'($urandom_range(0, 31));
        r_a1  = 5'($urandom_range(0, 31));
        r_a2  = 5'($urandom_range(0, 31));
      end
      set_in(1'($urandom_range(0, 1)), r_wrd, {$urandom, $urandom},
             1'($urandom_range(0, 1)), r_ird, ($urandom_range(0, 15) == 0),
             r_a1, r_a2);
      #1;
      check_model($sformatf("rnd%0d", n));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
